// File: rtl/binary_string_printer.sv
// binary_string_printer: collects ASCII '0'/'1' digits from UART rx and echoes them on tx.
// Define BINARY_STRING_HEX_EN to append " 0x<hex of value>" before the CR LF.
module binary_string_printer #(
    parameter int NUM_BITS = 8,
    parameter int REVERSE  = 1,
    parameter int CTR_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                new_rx_data,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    output logic [NUM_BITS-1:0] value,
    output logic                value_valid,
    output logic [CTR_W-1:0]    digit_count,
    output logic                printing
);
`ifdef BINARY_STRING_HEX_EN
    localparam int HEXD    = (NUM_BITS + 3) / 4;
    localparam int MSG_LEN = NUM_BITS + 5 + HEXD;
`else
    localparam int MSG_LEN = NUM_BITS + 2;
`endif
    localparam int IDX_W = $clog2(MSG_LEN);

    typedef enum logic [1:0] {COLLECT, PRINT, WAIT} state_e;

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] buf_q, buf_d;
    logic [NUM_BITS-1:0] value_q, value_d;
    logic                valid_q, valid_d;
    logic [CTR_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          tx_q, tx_d;
    logic                ntx_q, ntx_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [7:0] msg [MSG_LEN];
    logic [7:0] ch;
    logic       is_digit;
    logic       is_bs;

    assign is_digit = (rx_data[7:1] == 7'h18);
    assign is_bs    = (rx_data == 8'h08);

`ifdef BINARY_STRING_HEX_EN
    logic [4*HEXD-1:0] vpad;
    logic [3:0]        nib;
    assign vpad = (4*HEXD)'(value_q);
`endif

    // Whole outgoing message as a lookup table indexed by the print index.
    always_comb begin
`ifdef BINARY_STRING_HEX_EN
        nib = '0;
`endif
        for (int k = 0; k < NUM_BITS; k++) begin
            msg[k] = {7'h18, (REVERSE != 0) ? buf_q[NUM_BITS-1-k] : buf_q[k]};
        end
`ifdef BINARY_STRING_HEX_EN
        msg[NUM_BITS]   = 8'h20;
        msg[NUM_BITS+1] = 8'h30;
        msg[NUM_BITS+2] = 8'h78;
        for (int n = 0; n < HEXD; n++) begin
            nib = vpad[4*(HEXD-1-n) +: 4];
            msg[NUM_BITS+3+n] = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
        end
`endif
        msg[MSG_LEN-2] = 8'h0D;
        msg[MSG_LEN-1] = 8'h0A;
    end

    assign ch = msg[idx_q];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        value_d = value_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        ntx_d   = 1'b0;
        idx_d   = idx_q;
        unique case (state_q)
            COLLECT: begin
                if (new_rx_data && is_digit) begin
                    for (int k = 0; k < NUM_BITS; k++) begin
                        if (cnt_q == CTR_W'(k)) buf_d[k] = rx_data[0];
                    end
                    if (cnt_q == CTR_W'(NUM_BITS - 1)) begin
                        for (int k = 0; k < NUM_BITS; k++) begin
                            value_d[NUM_BITS-1-k] = buf_d[k];
                        end
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = PRINT;
                    end else begin
                        cnt_d = cnt_q + CTR_W'(1);
                    end
                end else if (new_rx_data && is_bs && cnt_q != '0) begin
                    cnt_d = cnt_q - CTR_W'(1);
                end
            end
            PRINT: begin
                if (!tx_busy) begin
                    tx_d    = ch;
                    ntx_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // One dead cycle lets the transmitter raise tx_busy.
                if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                    state_d = COLLECT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = PRINT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= COLLECT;
            buf_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            tx_q    <= '0;
            ntx_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            value_q <= value_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            ntx_q   <= ntx_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_data     = tx_q;
    assign new_tx_data = ntx_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign digit_count = cnt_q;
    assign printing    = (state_q != COLLECT);
endmodule
